aes_key_expander: RTL

Iterative AES-128 key schedule generator that sits directly upstream of the round datapath (initial, middle and final rounds) and supplies each round with its 128-bit round key. On `start` it latches the cipher key and derives one round key per clock. All 11 round keys are held in an internal register file. The round controller reads them by index once `ready` is high.

---
 rtl/aes_pkg.sv | 37 +++
 rtl/aes_sub_word.sv | 13 +
 rtl/aes_key_expander.sv | 113 +++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: round constants, word type, S-box and xtime.
// Used by the key schedule and the round datapath.
package aes_pkg;

  localparam int AES_NR = 10;
  localparam int AES_NK = 4;

  typedef logic [31:0] aes_word_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word.
// Purely combinational.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] w_i,
  output logic [31:0] w_o
);

  assign w_o = {sbox(w_i[31:24]), sbox(w_i[23:16]),
                sbox(w_i[15:8]),  sbox(w_i[7:0])};

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES-128 key schedule: one round key per clock,
// all round keys held in a register file with combinational read.
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         ready,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
);

  localparam logic [3:0] NR_W = 4'(NR);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXPAND,
    S_DONE
  } state_t;

  state_t       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         busy_q, busy_d;
  logic         ready_q, ready_d;
  logic [127:0] rk_q [0:NR];
  logic [127:0] rk_d [0:NR];

  logic [127:0] prev;
  aes_word_t    w0, w1, w2, w3;
  aes_word_t    sub, temp;
  aes_word_t    n0, n1, n2, n3;

  assign prev = rk_q[rnd_q - 4'd1];
  assign {w0, w1, w2, w3} = prev;

  aes_sub_word u_sub (
    .w_i ({w3[23:0], w3[31:24]}),
    .w_o (sub)
  );

  assign temp = sub ^ {rcon_q, 24'h0};
  assign n0   = w0 ^ temp;
  assign n1   = w1 ^ n0;
  assign n2   = w2 ^ n1;
  assign n3   = w3 ^ n2;

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    rcon_d  = rcon_q;
    busy_d  = busy_q;
    ready_d = ready_q;
    rk_d    = rk_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          rk_d[0] = key_in;
          rnd_d   = 4'd1;
          rcon_d  = 8'h01;
          state_d = S_EXPAND;
          busy_d  = 1'b1;
          ready_d = 1'b0;
        end else if (state_q == S_DONE) begin
          ready_d = 1'b1;
        end
      end
      S_EXPAND: begin
        rk_d[rnd_q] = {n0, n1, n2, n3};
        rcon_d      = xtime(rcon_q);
        if (rnd_q == NR_W) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rnd_q   <= '0;
      rcon_q  <= 8'h01;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      rcon_q  <= rcon_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      for (int i = 0; i <= NR; i++) rk_q[i] <= rk_d[i];
    end
  end

  assign busy   = busy_q;
  assign ready  = ready_q;
  assign rd_key = (rd_idx <= NR_W) ? rk_q[rd_idx] : '0;

endmodule
